// File: rtl/uart_tx_serializer.sv
// 8-bit UART transmitter: serialises a byte LSB-first as 8N1/8N2 with busy/done handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1/8E2).
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       send,
  output logic       tx,
  output logic       tx_busy,
  output logic       data_sent,
  output logic       tx_overrun
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             stop_idx, stop_idx_n;
  logic             busy_reg, busy_n;
  logic             tx_n, sent_n, overrun_n;
  logic             bit_done;
`ifdef UART_TX_PARITY_EN
  logic             par_reg, par_n;
`endif

  assign bit_done = (cnt == CNT_LAST);
  // The IDLE term stops a registered sender from firing twice in a row.
  assign tx_busy  = busy_reg | ((state == IDLE) & send);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    stop_idx_n = stop_idx;
    busy_n     = busy_reg;
    tx_n       = tx;
    sent_n     = 1'b0;
    overrun_n  = tx_overrun | (send & busy_reg);
`ifdef UART_TX_PARITY_EN
    par_n      = par_reg;
`endif
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (send) begin
          shift_n    = tx_data;
          cnt_n      = '0;
          bit_idx_n  = '0;
          stop_idx_n = 1'b0;
          busy_n     = 1'b1;
          tx_n       = 1'b0;
          state_n    = START;
`ifdef UART_TX_PARITY_EN
          par_n      = ^tx_data;
`endif
        end
      end
      START: begin
        if (bit_done) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          tx_n      = shift[0];
          state_n   = DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_n     = '0;
          shift_n   = shift >> 1;
          bit_idx_n = bit_idx + 3'd1;
          tx_n      = shift[1];
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_n    = par_reg;
            state_n = PARITY;
`else
            tx_n       = 1'b1;
            stop_idx_n = 1'b0;
            state_n    = STOP;
`endif
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          cnt_n      = '0;
          tx_n       = 1'b1;
          stop_idx_n = 1'b0;
          state_n    = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        tx_n = 1'b1;
        if (bit_done) begin
          cnt_n = '0;
          if (stop_idx == STOP_LAST) begin
            busy_n  = 1'b0;
            sent_n  = 1'b1;
            state_n = IDLE;
          end else begin
            stop_idx_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        // Corrupted encoding: fall back to a quiet idle line.
        state_n = IDLE;
        cnt_n   = '0;
        busy_n  = 1'b0;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      stop_idx   <= 1'b0;
      busy_reg   <= 1'b0;
      tx         <= 1'b1;
      data_sent  <= 1'b0;
      tx_overrun <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_reg    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shift      <= shift_n;
      stop_idx   <= stop_idx_n;
      busy_reg   <= busy_n;
      tx         <= tx_n;
      data_sent  <= sent_n;
      tx_overrun <= overrun_n;
`ifdef UART_TX_PARITY_EN
      par_reg    <= par_n;
`endif
    end
  end

endmodule
